// File: rtl/histo_stream_src.sv
// ---------------------------------------------------------------------------
// histo_stream_src
//
// Test-pattern frame source for the histogram block's AXI-stream rx port.
// A single-cycle start in IDLE latches the pattern mode, seed and frame
// length. The block then emits frame_len beats and pulses done once. After
// that it returns to IDLE and is ready for the next start.
//
// Parameters
//   P_DW       sample / tdata width in bits
//   P_LW       frame-length field width (max frame 2^P_LW-1 beats)
//
// Ports
//   aclk       sole clock, rising edge
//   areset_n   asynchronous active-low reset
//   start      single-cycle frame request (honoured only in IDLE)
//   mode       0 ramp, 1 constant, 2 alternate, 3 ramp
//   seed       first sample / constant value
//   frame_len  beats in the frame (0 = request ignored)
//   tdata      stream sample (registered)
//   tvalid     stream valid (registered)
//   tlast      final beat marker (registered)
//   tready     stream ready from sink
//   busy       high from the cycle after an accepted start until DONE exits
//   done       one-cycle pulse after the last beat transfers
//   frame_cnt  completed frame count, wraps 255 -> 0
// ---------------------------------------------------------------------------
module histo_stream_src #(
  parameter int P_DW = 4,
  parameter int P_LW = 8
) (
  input  logic            aclk,
  input  logic            areset_n,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [P_DW-1:0] seed,
  input  logic [P_LW-1:0] frame_len,
  output logic [P_DW-1:0] tdata,
  output logic            tvalid,
  output logic            tlast,
  input  logic            tready,
  output logic            busy,
  output logic            done,
  output logic [7:0]      frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [P_LW-1:0] LW_ZERO = {P_LW{1'b0}};
  localparam logic [P_LW-1:0] LW_ONE  = {{(P_LW-1){1'b0}}, 1'b1};
  localparam logic [P_DW-1:0] DW_ZERO = {P_DW{1'b0}};

  state_t          state_r, state_s;
  logic [1:0]      mode_r, mode_s;
  logic [P_DW-1:0] seed_r, seed_s;
  logic [P_LW-1:0] len_r, len_s;
  logic [P_LW-1:0] idx_r, idx_s;
  logic [P_LW-1:0] idx_inc_s;
  logic [P_DW-1:0] tdata_r, tdata_s;
  logic            tvalid_r, tvalid_s;
  logic            tlast_r, tlast_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;
  logic [7:0]      cnt_r, cnt_s;

  // Sample value for beat index i of the selected pattern.
  // Ramp wraps silently. Mode 3 falls through to ramp.
  function automatic logic [P_DW-1:0] pattern_sample(
    input logic [1:0]      m,
    input logic [P_DW-1:0] s,
    input logic [P_LW-1:0] i
  );
    logic [P_DW-1:0] idx_w;
    idx_w = P_DW'(i);
    case (m)
      2'd1:    pattern_sample = s;
      2'd2:    pattern_sample = i[0] ? ~s : s;
      default: pattern_sample = s + idx_w;
    endcase
  endfunction

  // Next-state and next-output logic.
  // All outputs are computed here and registered below, so tready reaches
  // tvalid/tdata only through a flop.
  always_comb begin
    state_s   = state_r;
    mode_s    = mode_r;
    seed_s    = seed_r;
    len_s     = len_r;
    idx_s     = idx_r;
    tdata_s   = tdata_r;
    tvalid_s  = tvalid_r;
    tlast_s   = tlast_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    cnt_s     = cnt_r;
    idx_inc_s = idx_r + LW_ONE;

    case (state_r)
      ST_IDLE: begin
        if (start && (frame_len != LW_ZERO)) begin
          state_s  = ST_SEND;
          mode_s   = mode;
          seed_s   = seed;
          len_s    = frame_len;
          idx_s    = LW_ZERO;
          tdata_s  = pattern_sample(mode, seed, LW_ZERO);
          tvalid_s = 1'b1;
          tlast_s  = (frame_len == LW_ONE);
          busy_s   = 1'b1;
        end else begin
          tvalid_s = 1'b0;
          tlast_s  = 1'b0;
          busy_s   = 1'b0;
        end
      end

      ST_SEND: begin
        if (tvalid_r && tready) begin
          // tlast_r already encodes idx == len-1 for the beat on the bus.
          if (tlast_r) begin
            state_s  = ST_DONE;
            tvalid_s = 1'b0;
            tlast_s  = 1'b0;
            done_s   = 1'b1;
            cnt_s    = cnt_r + 8'd1;
          end else begin
            idx_s   = idx_inc_s;
            tdata_s = pattern_sample(mode_r, seed_r, idx_inc_s);
            tlast_s = (idx_inc_s == (len_r - LW_ONE));
          end
        end else begin
          // Stalled: hold the beat on the bus unchanged.
          tdata_s  = tdata_r;
          tlast_s  = tlast_r;
          tvalid_s = tvalid_r;
        end
      end

      ST_DONE: begin
        state_s  = ST_IDLE;
        busy_s   = 1'b0;
        tvalid_s = 1'b0;
        tlast_s  = 1'b0;
      end

      default: begin
        state_s  = ST_IDLE;
        tvalid_s = 1'b0;
        tlast_s  = 1'b0;
        busy_s   = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_r  <= ST_IDLE;
      mode_r   <= 2'd0;
      seed_r   <= DW_ZERO;
      len_r    <= LW_ZERO;
      idx_r    <= LW_ZERO;
      tdata_r  <= DW_ZERO;
      tvalid_r <= 1'b0;
      tlast_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      cnt_r    <= 8'd0;
    end else begin
      state_r  <= state_s;
      mode_r   <= mode_s;
      seed_r   <= seed_s;
      len_r    <= len_s;
      idx_r    <= idx_s;
      tdata_r  <= tdata_s;
      tvalid_r <= tvalid_s;
      tlast_r  <= tlast_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      cnt_r    <= cnt_s;
    end
  end

  assign tdata     = tdata_r;
  assign tvalid    = tvalid_r;
  assign tlast     = tlast_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign frame_cnt = cnt_r;

endmodule

// File: tb/tb_histo_stream_src.sv
// ---------------------------------------------------------------------------
// tb_histo_stream_src
//
// Self-checking bench for histo_stream_src. Expected beats come from a
// pattern model written directly from the pattern rules (integer arithmetic
// on beat index). Each cycle the bench compares the stream outputs, busy,
// done and frame_cnt against the model's expectation.
// ---------------------------------------------------------------------------
module tb_histo_stream_src;

  logic       aclk;
  logic       areset_n;
  logic       start;
  logic [1:0] mode;
  logic [3:0] seed;
  logic [7:0] frame_len;
  logic [3:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tready;
  logic       busy;
  logic       done;
  logic [7:0] frame_cnt;

  int n_checks;
  int n_fails;
  int exp_cnt;

  histo_stream_src #(.P_DW(4), .P_LW(8)) dut (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .start     (start),
    .mode      (mode),
    .seed      (seed),
    .frame_len (frame_len),
    .tdata     (tdata),
    .tvalid    (tvalid),
    .tlast     (tlast),
    .tready    (tready),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Pattern rule for beat i: ramp (seed+i) mod 16, constant seed,
  // alternate seed / ~seed on even / odd beats.
  function automatic logic [3:0] model_sample(input int m, input int sd, input int i);
    int v;
    case (m)
      1:       v = sd;
      2:       v = ((i % 2) == 0) ? sd : ~sd;
      default: v = sd + i;
    endcase
    return 4'(v & 15);
  endfunction

  // Drives one full frame and checks every cycle of it, ending in the IDLE
  // cycle that follows DONE (so the next start may be issued immediately).
  task automatic run_frame(input int m, input int sd, input int len,
                           input int smin, input int smax, input bit perturb);
    int n;
    logic [3:0] exp_d;
    mode      = 2'(m);
    seed      = 4'(sd);
    frame_len = 8'(len);
    start     = 1'b1;
    tready    = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    for (int i = 0; i < len; i++) begin
      n     = $urandom_range(smin, smax);
      exp_d = model_sample(m, sd, i);
      for (int s = 0; s <= n; s++) begin
        tready = (s == n);
        if (perturb) begin
          mode      = 2'($urandom);
          seed      = 4'($urandom);
          frame_len = 8'($urandom);
          start     = 1'($urandom_range(0, 1));
        end
        check_eq("tvalid_beat", 32'(tvalid), 32'd1);
        check_eq("tdata_beat", 32'(tdata), 32'(exp_d));
        check_eq("tlast_beat", 32'(tlast), 32'(i == len - 1));
        check_eq("busy_beat", 32'(busy), 32'd1);
        check_eq("done_beat", 32'(done), 32'd0);
        tick();
      end
    end
    // DONE cycle; a start here must not be taken.
    start     = perturb;
    frame_len = 8'd5;
    tready    = 1'($urandom_range(0, 1));
    exp_cnt   = (exp_cnt + 1) % 256;
    check_eq("tvalid_done", 32'(tvalid), 32'd0);
    check_eq("tlast_done", 32'(tlast), 32'd0);
    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("busy_done", 32'(busy), 32'd1);
    check_eq("cnt_done", 32'(frame_cnt), 32'(exp_cnt));
    tick();
    start = 1'b0;
    check_eq("tvalid_idle", 32'(tvalid), 32'd0);
    check_eq("done_idle", 32'(done), 32'd0);
    check_eq("busy_idle", 32'(busy), 32'd0);
    check_eq("cnt_idle", 32'(frame_cnt), 32'(exp_cnt));
  endtask

  initial begin
    int saved_cnt;
    int m;
    n_checks  = 0;
    n_fails   = 0;
    exp_cnt   = 0;
    areset_n  = 1'b0;
    start     = 1'b0;
    mode      = 2'd0;
    seed      = 4'd0;
    frame_len = 8'd0;
    tready    = 1'b0;

    // Reset state.
    tick();
    tick();
    check_eq("rst_tvalid", 32'(tvalid), 32'd0);
    check_eq("rst_tlast", 32'(tlast), 32'd0);
    check_eq("rst_tdata", 32'(tdata), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_cnt", 32'(frame_cnt), 32'd0);

    // Release and start on the very first edge: ramp E,F,0,1.
    areset_n = 1'b1;
    run_frame(0, 14, 4, 0, 0, 1'b0);

    // Backpressure, alternate 5,A,5, three stall cycles per beat.
    run_frame(2, 5, 3, 3, 3, 1'b0);

    // Zero-length start is ignored.
    frame_len = 8'd0;
    start     = 1'b1;
    tready    = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("zl_tvalid", 32'(tvalid), 32'd0);
      check_eq("zl_done", 32'(done), 32'd0);
      check_eq("zl_busy", 32'(busy), 32'd0);
      check_eq("zl_cnt", 32'(frame_cnt), 32'(exp_cnt));
      tick();
    end

    // Starts and input changes mid-frame are ignored.
    run_frame(0, 9, 6, 0, 2, 1'b1);
    run_frame(2, 3, 5, 0, 1, 1'b1);

    // Mid-frame reset after two beats of an 8-beat frame.
    mode      = 2'd0;
    seed      = 4'd7;
    frame_len = 8'd8;
    tready    = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_eq("mr_tdata", 32'(tdata), 32'(model_sample(0, 7, i)));
      check_eq("mr_tvalid", 32'(tvalid), 32'd1);
      tick();
    end
    areset_n = 1'b0;
    #1;
    exp_cnt = 0;
    check_eq("mr_rst_tvalid", 32'(tvalid), 32'd0);
    check_eq("mr_rst_tlast", 32'(tlast), 32'd0);
    check_eq("mr_rst_tdata", 32'(tdata), 32'd0);
    check_eq("mr_rst_busy", 32'(busy), 32'd0);
    check_eq("mr_rst_cnt", 32'(frame_cnt), 32'd0);
    tick();
    areset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("mr_post_tvalid", 32'(tvalid), 32'd0);
      check_eq("mr_post_done", 32'(done), 32'd0);
      check_eq("mr_post_cnt", 32'(frame_cnt), 32'd0);
    end
    run_frame(0, 7, 8, 0, 1, 1'b0);

    // Randomized frames over every mode.
    for (int f = 0; f < 20; f++) begin
      m = $urandom_range(0, 3);
      run_frame(m, $urandom_range(0, 15), $urandom_range(1, 20), 0, 2, 1'($urandom_range(0, 1)));
    end

    // 256 back-to-back single-beat constant frames wrap frame_cnt.
    saved_cnt = exp_cnt;
    for (int f = 0; f < 256; f++) begin
      run_frame(1, f % 16, 1, 0, 0, 1'b0);
    end
    check_eq("wrap_cnt", 32'(frame_cnt), 32'(saved_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
